hub75_bcm_driver: RTL and testbench

Parametrised HUB75 LED-matrix scan driver with binary-code-modulation (BCM) grey scale, global brightness and a tick-enable architecture: no derived clock. It drives a dual-scan panel (upper and lower halves shifted in parallel) from an external frame memory with one-cycle read latency. It replaces the fixed 64×64, 4-bit, divided-clock panel driver and sits between the frame buffer and the panel connector.

---
 rtl/hub75_bcm_driver.sv | 176 +++++++++++++++++
 tb/tb_hub75_bcm_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver: dual-scan HUB75 panel driver with BCM grey scale, global brightness and tick-enable timing
module hub75_bcm_driver #(
  parameter int NUM_COLS   = 64,
  parameter int NUM_ROWS   = 64,
  parameter int BIT_DEPTH  = 4,
  parameter int CLK_DIV    = 3,
  parameter int BASE_DELAY = 20,
  localparam int SCAN = NUM_ROWS / 2,
  localparam int RW   = $clog2(SCAN),
  localparam int CW   = $clog2(NUM_COLS),
  localparam int AW   = RW + CW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [7:0]               brightness,
  output logic [AW-1:0]            pix_addr,
  input  logic [6*BIT_DEPTH-1:0]   pix_data,
  output logic                     LP_CLK,
  output logic                     LATCH,
  output logic                     NOE,
  output logic [RW-1:0]            ROW,
  output logic [2:0]               RGB0,
  output logic [2:0]               RGB1,
  output logic                     frame_done
);
  localparam int PMAX = BASE_DELAY << (BIT_DEPTH - 1);
  localparam int DW   = $clog2(PMAX) + 1;
  localparam int MW   = $clog2(PMAX) + 8;
  localparam int PW   = BIT_DEPTH > 1 ? $clog2(BIT_DEPTH) : 1;
  localparam int VW   = $clog2(CLK_DIV);

  typedef enum logic [2:0] {ST_IDLE, ST_SHIFT_LO, ST_SHIFT_HI, ST_BLANK, ST_LATCH, ST_DISPLAY} state_t;

  state_t              state_q, state_d;
  logic [VW-1:0]       div_q, div_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       r_q, r_d, row_q, row_d;
  logic [PW-1:0]       b_q, b_d;
  logic [DW-1:0]       d_q, d_d;
  logic [7:0]          br_q, br_d;
  logic                lp_q, lp_d, latch_q, latch_d, noe_q, noe_d, fd_q, fd_d;
  logic [2:0]          rgb0_q, rgb0_d, rgb1_q, rgb1_d;
  logic                tick;
  logic [DW-1:0]       period, on_b;
  logic [MW-1:0]       prod;
  logic [BIT_DEPTH-1:0] ch [6];

  for (genvar g = 0; g < 6; g++) begin : g_ch
    assign ch[g] = pix_data[(5-g)*BIT_DEPTH +: BIT_DEPTH];
  end

  assign tick     = div_q == VW'(CLK_DIV - 1);
  assign period   = DW'(BASE_DELAY) << b_q;
  assign prod     = MW'(period) * MW'(br_q);
  assign on_b     = DW'(prod >> 8);
  assign pix_addr = {r_q, col_q};

  assign LP_CLK     = lp_q;
  assign LATCH      = latch_q;
  assign NOE        = noe_q;
  assign ROW        = row_q;
  assign RGB0       = rgb0_q;
  assign RGB1       = rgb1_q;
  assign frame_done = fd_q;

  // scan sequencer: all state and panel outputs advance only on tick; outputs reflect the state just left
  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + VW'(1);
    col_d   = col_q;
    r_d     = r_q;
    b_d     = b_q;
    d_d     = d_q;
    br_d    = br_q;
    lp_d    = lp_q;
    latch_d = latch_q;
    noe_d   = noe_q;
    row_d   = row_q;
    rgb0_d  = rgb0_q;
    rgb1_d  = rgb1_q;
    fd_d    = 1'b0;
    if (tick) begin
      lp_d    = 1'b0;
      latch_d = 1'b0;
      noe_d   = 1'b1;
      unique case (state_q)
        ST_IDLE: if (en) begin
          br_d    = brightness;
          r_d     = '0;
          b_d     = '0;
          col_d   = '0;
          state_d = ST_SHIFT_LO;
        end
        ST_SHIFT_LO: begin
          rgb0_d  = {ch[0][b_q], ch[1][b_q], ch[2][b_q]};
          rgb1_d  = {ch[3][b_q], ch[4][b_q], ch[5][b_q]};
          state_d = ST_SHIFT_HI;
        end
        ST_SHIFT_HI: begin
          lp_d    = 1'b1;
          state_d = col_q == CW'(NUM_COLS - 1) ? ST_BLANK : ST_SHIFT_LO;
          col_d   = col_q == CW'(NUM_COLS - 1) ? col_q : col_q + CW'(1);
        end
        ST_BLANK: begin
          row_d   = r_q;
          state_d = ST_LATCH;
        end
        ST_LATCH: begin
          latch_d = 1'b1;
          d_d     = '0;
          state_d = ST_DISPLAY;
        end
        ST_DISPLAY: begin
          noe_d = d_q >= on_b;
          d_d   = d_q + DW'(1);
          if (d_q == period - DW'(1)) begin
            d_d   = '0;
            col_d = '0;
            if (b_q != PW'(BIT_DEPTH - 1)) begin
              b_d     = b_q + PW'(1);
              state_d = ST_SHIFT_LO;
            end else begin
              b_d = '0;
              if (r_q != RW'(SCAN - 1)) begin
                r_d     = r_q + RW'(1);
                state_d = ST_SHIFT_LO;
              end else begin
                fd_d    = 1'b1;
                r_d     = '0;
                br_d    = en ? brightness : br_q;
                state_d = en ? ST_SHIFT_LO : ST_IDLE;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // state and output registers, blanked panel on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      col_q   <= '0;
      r_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      br_q    <= '0;
      lp_q    <= 1'b0;
      latch_q <= 1'b0;
      noe_q   <= 1'b1;
      row_q   <= '0;
      rgb0_q  <= '0;
      rgb1_q  <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      col_q   <= col_d;
      r_q     <= r_d;
      b_q     <= b_d;
      d_q     <= d_d;
      br_q    <= br_d;
      lp_q    <= lp_d;
      latch_q <= latch_d;
      noe_q   <= noe_d;
      row_q   <= row_d;
      rgb0_q  <= rgb0_d;
      rgb1_q  <= rgb1_d;
      fd_q    <= fd_d;
    end
  end
endmodule

// File: tb/tb_hub75_bcm_driver.sv
// tb_hub75_bcm_driver: randomized scoreboard bench for hub75_bcm_driver against a frame-level reference model
module tb_hub75_bcm_driver;
  localparam int COLS = 4;
  localparam int ROWS = 4;
  localparam int BD   = 2;
  localparam int CDIV = 2;
  localparam int BASE = 3;
  localparam int SCAN = ROWS / 2;
  localparam int RW   = $clog2(SCAN);
  localparam int AW   = RW + $clog2(COLS);
  localparam int FRAME_CLK = CDIV * SCAN * (BD * (2 * COLS + 2) + BASE * ((1 << BD) - 1));

  typedef struct {
    int kind;
    logic [5:0] rgb;
    int row;
    int on;
  } ev_t;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [7:0] brightness = '0;
  logic [AW-1:0] pix_addr;
  logic [6*BD-1:0] pix_data = '0;
  logic LP_CLK, LATCH, NOE, frame_done;
  logic [RW-1:0] ROW;
  logic [2:0] RGB0, RGB1;

  logic [6*BD-1:0] mem [1 << AW];
  ev_t evq [$];
  ev_t mev;
  int checks = 0, errors = 0, cyc = 0;
  bit mon_on = 1'b0, pend = 1'b0;
  int pend_on = 0, noe_cnt = 0;
  logic lp_prev = 1'b0, latch_prev = 1'b0, fd_prev = 1'b0;
  logic [RW-1:0] row_prev = '0;
  logic [5:0] rgb_prev = '0;

  hub75_bcm_driver #(.NUM_COLS(COLS), .NUM_ROWS(ROWS), .BIT_DEPTH(BD), .CLK_DIV(CDIV), .BASE_DELAY(BASE)) dut (
    .clk(clk), .rst(rst), .en(en), .brightness(brightness), .pix_addr(pix_addr), .pix_data(pix_data),
    .LP_CLK(LP_CLK), .LATCH(LATCH), .NOE(NOE), .ROW(ROW), .RGB0(RGB0), .RGB1(RGB1), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) pix_data <= mem[pix_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // expected panel traffic for one whole frame at brightness br
  task automatic push_frame(input int br);
    ev_t e;
    logic [6*BD-1:0] px;
    for (int r = 0; r < SCAN; r++)
      for (int b = 0; b < BD; b++) begin
        for (int c = 0; c < COLS; c++) begin
          px = mem[r * COLS + c];
          e = '{kind: 0, rgb: {px[5*BD+b], px[4*BD+b], px[3*BD+b], px[2*BD+b], px[BD+b], px[b]}, row: 0, on: 0};
          evq.push_back(e);
        end
        e = '{kind: 1, rgb: '0, row: r, on: (BASE * (1 << b) * br) / 256};
        evq.push_back(e);
      end
    e = '{kind: 2, rgb: '0, row: 0, on: 0};
    evq.push_back(e);
  endtask

  task automatic wait_fd(output int t);
    int n;
    for (n = 0; n < 4 * FRAME_CLK; n++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    chk("frame_done_timeout", int'(n < 4 * FRAME_CLK), 1);
    t = cyc;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_noe"}, NOE, 1);
    chk({tag, "_lp_clk"}, LP_CLK, 0);
    chk({tag, "_latch"}, LATCH, 0);
    chk({tag, "_row"}, ROW, 0);
    chk({tag, "_rgb0"}, RGB0, 0);
    chk({tag, "_rgb1"}, RGB1, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_pix_addr"}, pix_addr, 0);
  endtask

  // monitor: pops the scoreboard on every LP_CLK rise, LATCH rise and frame_done pulse
  always @(negedge clk) begin
    if (mon_on) begin
      if (pend && !NOE) noe_cnt++;
      if (ROW != row_prev) chk("row_change_blanked", NOE, 1);
      if (LP_CLK && !lp_prev) begin
        chk("shift_event", evq.size() > 0 ? evq[0].kind : -1, 0);
        if (evq.size() > 0 && evq[0].kind == 0) begin
          mev = evq.pop_front();
          chk("rgb_data", {RGB0, RGB1}, mev.rgb);
          chk("rgb_setup", {RGB0, RGB1}, rgb_prev);
        end
      end
      if (LATCH && !latch_prev) begin
        if (pend) chk("noe_on_clks", noe_cnt, pend_on * CDIV);
        pend = 1'b0;
        chk("latch_event", evq.size() > 0 ? evq[0].kind : -1, 1);
        if (evq.size() > 0 && evq[0].kind == 1) begin
          mev = evq.pop_front();
          chk("latch_row", ROW, mev.row);
          pend = 1'b1;
          pend_on = mev.on;
          noe_cnt = 0;
        end
      end
      if (frame_done) begin
        chk("frame_done_width", fd_prev, 0);
        if (pend) chk("noe_on_clks", noe_cnt, pend_on * CDIV);
        pend = 1'b0;
        chk("frame_end_event", evq.size() > 0 ? evq[0].kind : -1, 2);
        if (evq.size() > 0 && evq[0].kind == 2) mev = evq.pop_front();
      end
    end
    lp_prev = LP_CLK;
    latch_prev = LATCH;
    fd_prev = frame_done;
    row_prev = ROW;
    rgb_prev = {RGB0, RGB1};
  end

  initial begin
    int t1, t2, t3, n;
    for (int a = 0; a < (1 << AW); a++) mem[a] = {2'b10, {(6*BD-2){1'b0}}};
    repeat (3) @(negedge clk);
    chk_outputs("reset");
    rst = 1'b1;
    mon_on = 1'b1;
    repeat (3) @(negedge clk);
    brightness = 8'd255;
    push_frame(255);
    en = 1'b1;
    repeat (30) @(negedge clk);
    brightness = 8'd128;
    push_frame(128);
    wait_fd(t1);
    repeat (30) @(negedge clk);
    brightness = 8'd0;
    push_frame(0);
    wait_fd(t2);
    chk("frame_period", t2 - t1, FRAME_CLK);
    repeat (30) @(negedge clk);
    en = 1'b0;
    brightness = 8'd77;
    wait_fd(t3);
    chk("frame_period", t3 - t2, FRAME_CLK);
    repeat (10) @(negedge clk);
    chk("idle_noe", NOE, 1);
    chk("idle_lp_clk", LP_CLK, 0);
    chk("idle_queue_left", evq.size(), 0);

    for (int a = 0; a < (1 << AW); a++) mem[a] = (6*BD)'($urandom);
    brightness = 8'($urandom_range(1, 254));
    push_frame(brightness);
    en = 1'b1;
    repeat (30) @(negedge clk);
    en = 1'b0;
    wait_fd(t1);
    repeat (10) @(negedge clk);
    chk("idle2_noe", NOE, 1);
    chk("idle2_queue_left", evq.size(), 0);

    brightness = 8'($urandom_range(128, 254));
    push_frame(brightness);
    en = 1'b1;
    for (n = 0; n < 8; n++) begin
      @(negedge clk);
      if (LP_CLK) break;
    end
    chk("restart_first_lp_clk", int'(n < 8), 1);
    for (n = 0; n < 2 * FRAME_CLK; n++) begin
      @(negedge clk);
      if (!NOE) break;
    end
    chk("display_reached", int'(n < 2 * FRAME_CLK), 1);
    mon_on = 1'b0;
    #1 rst = 1'b0;
    #1 chk_outputs("async_reset");
    evq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
